// File: rtl/cond_flag_unit.sv
// NZCV flag register, decode-time condition latch and write-strobe gating
// for the multi-cycle ARM datapath.
module cond_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             ALUCarry,
  input  logic             ALUOverflow,
  input  logic             ALUArith,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             DecodeStrobe,
  input  logic             ExecStrobe,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic [3:0]       Flags,
  output logic             CondExQ,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             FlagsUpd
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       flags_upd_q, flags_upd_d;
  logic       alu_n, alu_z;
  logic       upd_en, wr_nz, wr_cv;

  assign alu_n = ALUResult[WIDTH-1];
  assign alu_z = ~|ALUResult;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    // The update is gated by the condition latched for this instruction, even
    // when a new decode strobe reloads it on the same edge.
    upd_en    = ExecStrobe & cond_ex_q;
    wr_nz     = upd_en & FlagW[1];
    wr_cv     = upd_en & FlagW[0] & ALUArith;
    if (wr_nz) flags_d[3:2] = {alu_n, alu_z};
    if (wr_cv) flags_d[1:0] = {ALUCarry, ALUOverflow};
    if (DecodeStrobe) cond_ex_d = CondEx;
    flags_upd_d = wr_nz | wr_cv;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= 4'b0000;
      cond_ex_q   <= 1'b0;
      flags_upd_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      cond_ex_q   <= cond_ex_d;
      flags_upd_q <= flags_upd_d;
    end
  end

  assign Flags    = flags_q;
  assign CondExQ  = cond_ex_q;
  assign FlagsUpd = flags_upd_q;

  // A failed condition suppresses everything except the fetch increment.
  assign PCWrite  = (PCS & cond_ex_q) | NextPC;
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios followed by
// randomized cycles compared against a behavioural flag model.
module tb_cond_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResult;
  logic        ALUCarry, ALUOverflow, ALUArith;
  logic [1:0]  FlagW;
  logic        CondEx, DecodeStrobe, ExecStrobe;
  logic        PCS, NextPC, RegW, MemW;
  logic [3:0]  Flags;
  logic        CondExQ, PCWrite, RegWrite, MemWrite, FlagsUpd;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_n, m_z, m_c, m_v, m_cq, m_upd;

  cond_flag_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUResult(ALUResult), .ALUCarry(ALUCarry),
    .ALUOverflow(ALUOverflow), .ALUArith(ALUArith), .FlagW(FlagW),
    .CondEx(CondEx), .DecodeStrobe(DecodeStrobe), .ExecStrobe(ExecStrobe),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Flags(Flags),
    .CondExQ(CondExQ), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .FlagsUpd(FlagsUpd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    {m_n, m_z, m_c, m_v, m_cq, m_upd} = '0;
  endtask

  // One instruction-level step of the architectural rules.
  task automatic model_step();
    bit do_upd, wrote;
    do_upd = ExecStrobe && m_cq;
    wrote  = 1'b0;
    if (do_upd && FlagW[1]) begin
      m_n   = ALUResult[31];
      m_z   = (ALUResult == 32'd0);
      wrote = 1'b1;
    end
    if (do_upd && FlagW[0] && ALUArith) begin
      m_c   = ALUCarry;
      m_v   = ALUOverflow;
      wrote = 1'b1;
    end
    m_upd = wrote;
    if (DecodeStrobe) m_cq = CondEx;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".flags"},  Flags,    {m_n, m_z, m_c, m_v});
    check({pfx, ".cq"},     CondExQ,  m_cq);
    check({pfx, ".upd"},    FlagsUpd, m_upd);
    check({pfx, ".pcw"},    PCWrite,  (PCS && m_cq) || NextPC);
    check({pfx, ".regw"},   RegWrite, RegW && m_cq);
    check({pfx, ".memw"},   MemWrite, MemW && m_cq);
  endtask

  task automatic idle();
    ALUResult = 32'h1; {ALUCarry, ALUOverflow, ALUArith} = '0; FlagW = 2'b00;
    {CondEx, DecodeStrobe, ExecStrobe, PCS, NextPC, RegW, MemW} = '0;
  endtask

  // Clock edge, model update, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic decode(input bit cond);
    idle(); DecodeStrobe = 1'b1; CondEx = cond; tick(); idle();
  endtask

  task automatic exec(input logic [31:0] res, input bit carry, input bit ovf,
                      input bit arith, input logic [1:0] fw);
    idle(); ExecStrobe = 1'b1; ALUResult = res; ALUCarry = carry;
    ALUOverflow = ovf; ALUArith = arith; FlagW = fw; tick(); idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst.flags", Flags, 4'b0000);
    check("rst.cq", CondExQ, 1'b0);
    check("rst.upd", FlagsUpd, 1'b0);

    // SUBS with zero result
    decode(1'b1);
    exec(32'd0, 1'b1, 1'b0, 1'b1, 2'b11);
    check("subs.flags", Flags, 4'b0110);
    check("subs.upd", FlagsUpd, 1'b1);
    tick();
    check("subs.upd_once", FlagsUpd, 1'b0);

    // Bring flags to 0011, then a logic op must keep C/V
    exec(32'd1, 1'b1, 1'b1, 1'b1, 2'b11);
    check("setup.0011", Flags, 4'b0011);
    exec(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b11);
    check("logic.flags", Flags, 4'b1011);

    // ExecStrobe with FlagW=00
    exec(32'd0, 1'b0, 1'b0, 1'b1, 2'b00);
    check("fw00.flags", Flags, 4'b1011);
    check("fw00.upd", FlagsUpd, 1'b0);

    // Condition fail
    decode(1'b0);
    ExecStrobe = 1'b1; FlagW = 2'b11; ALUResult = 32'd0; ALUArith = 1'b1;
    ALUCarry = 1'b0; ALUOverflow = 1'b1;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    #1;
    check("fail.regw", RegWrite, 1'b0);
    check("fail.memw", MemWrite, 1'b0);
    check("fail.pcw", PCWrite, 1'b0);
    NextPC = 1'b1;
    #1;
    check("fail.nextpc", PCWrite, 1'b1);
    tick(); idle();
    check("fail.flags", Flags, 4'b1011);
    check("fail.upd", FlagsUpd, 1'b0);

    // Simultaneous decode and execute strobes
    decode(1'b1);
    DecodeStrobe = 1'b1; ExecStrobe = 1'b1; CondEx = 1'b0;
    FlagW = 2'b10; ALUResult = 32'd0; ALUArith = 1'b1; ALUCarry = 1'b0;
    tick(); idle();
    check("simul.flags", Flags, 4'b0111);
    check("simul.cq", CondExQ, 1'b0);

    // Partial write: C/V only; N,Z must not follow the result
    decode(1'b1);
    exec(32'd0, 1'b0, 1'b0, 1'b1, 2'b11);
    check("setup.0100", Flags, 4'b0100);
    exec(32'h8000_0000, 1'b1, 1'b1, 1'b1, 2'b01);
    check("partial.cv", Flags, 4'b0111);
    exec(32'h8000_0000, 1'b0, 1'b0, 1'b1, 2'b10);
    check("partial.nz", Flags, 4'b1011);

    // Reset mid-instruction, asserted away from any edge
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.flags", Flags, 4'b0000);
    check("midrst.cq", CondExQ, 1'b0);
    check("midrst.regw", RegWrite, 1'b0);
    check("midrst.memw", MemWrite, 1'b0);
    check("midrst.pcw", PCWrite, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;

    // Randomized cycles against the model
    for (int i = 0; i < 600; i++) begin
      ALUResult    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ALUCarry     = 1'($urandom);
      ALUOverflow  = 1'($urandom);
      ALUArith     = 1'($urandom);
      FlagW        = 2'($urandom);
      CondEx       = ($urandom_range(0, 3) != 0);
      DecodeStrobe = ($urandom_range(0, 2) == 0);
      ExecStrobe   = ($urandom_range(0, 1) == 0);
      PCS          = 1'($urandom);
      NextPC       = 1'($urandom);
      RegW         = 1'($urandom);
      MemW         = 1'($urandom);
      #1;
      check_all("rnd.pre");
      tick();
      check_all("rnd.post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Sequential companion of the condition-check logic in the multi-cycle ARM datapath. It holds the architectural NZCV flag register, derives new flags from the ALU outputs, and latches the condition-pass decision at decode. It then gates the controller's PC, register-file and memory write strobes for the rest of the instruction. Its `Flags` output is the flag vector the condition checker evaluates; this block is the writer of those flags.

## Interface
- `WIDTH`, 32, ALU datapath width; `ALUResult` is `WIDTH` bits.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ALUResult`  in  WIDTH  ALU result of the current execute cycle
- `ALUCarry`  in  1  ALU carry-out (add/sub)
- `ALUOverflow`  in  1  ALU signed overflow (add/sub)
- `ALUArith`  in  1  1 = current ALU op is add/sub, so C and V are valid
- `FlagW`  in  2  flag write request; bit1 = N,Z; bit0 = C,V
- `CondEx`  in  1  condition-pass from the condition checker, evaluated against the current `Flags`
- `DecodeStrobe`  in  1  controller in decode state; latch `CondEx`
- `ExecStrobe`  in  1  controller in ALU execute state; flag update permitted
- `PCS`  in  1  controller PC-write request, conditional
- `NextPC`  in  1  controller unconditional PC write (fetch increment)
- `RegW`  in  1  controller register-write request
- `MemW`  in  1  controller memory-write request
- `Flags`  out  4  registered {N,Z,C,V}
- `CondExQ`  out  1  latched condition-pass for the current instruction
- `PCWrite`  out  1  gated PC write
- `RegWrite`  out  1  gated register write
- `MemWrite`  out  1  gated memory write
- `FlagsUpd`  out  1  one-cycle pulse, high the cycle after any flag bit was written

## Operation
- Flag derivation is combinational from the ALU outputs:
  - N = `ALUResult[WIDTH-1]`
  - Z = NOR of all `ALUResult` bits
  - C = `ALUCarry`
  - V = `ALUOverflow`
- Update condition is `ExecStrobe & CondExQ`. When it holds:
  - If `FlagW[1]`, write N and Z.
  - If `FlagW[0] & ALUArith`, write C and V.
  - If `FlagW[0] & ~ALUArith`, C and V hold. Logic ops never disturb the carry or overflow flags.
- Bits not written hold their value. Each half is independent: `FlagW`=10 touches only N and Z; `FlagW`=01 touches only C and V.
- `CondExQ` loads `CondEx` on every edge where `DecodeStrobe`=1. Otherwise it holds.
- Write gating is combinational from `CondExQ` and the current requests:
  - `PCWrite` = (`PCS` & `CondExQ`) | `NextPC`
  - `RegWrite` = `RegW` & `CondExQ`
  - `MemWrite` = `MemW` & `CondExQ`
- A failed condition (`CondExQ`=0) therefore suppresses every architectural side effect of the instruction except the fetch-increment PC write.
- `FlagsUpd` registers the OR of all bit-write enables of the previous cycle.

## Timing
- Reset (`rst_n`=0, asynchronous, no clock needed):
  - `Flags`=4'b0000, `CondExQ`=0, `FlagsUpd`=0.
  - Gated outputs are then 0 except `PCWrite`=`NextPC`.
- Reset deassertion is sampled synchronously; the first update may occur on the first rising edge with `rst_n`=1.
- Flag update latency: new `Flags` are visible 1 cycle after the `ExecStrobe` edge. `FlagsUpd` is high in that same cycle.
- `CondEx` must be stable at the `DecodeStrobe` edge. `CondExQ` is valid from the next cycle until the next `DecodeStrobe`.
- `DecodeStrobe` and `ExecStrobe` in the same cycle:
  - The flag update is gated by the old `CondExQ`.
  - `CondExQ` simultaneously loads `CondEx`, which was computed from the pre-update `Flags`.
- `ExecStrobe`=1 with `FlagW`=00: no flag change and no `FlagsUpd`.
- Reset mid-instruction: flags and `CondExQ` clear immediately. Gated writes drop in the same cycle.
- No other state exists; all outputs are defined in every cycle.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle -> `Flags`=0000 and `CondExQ`=0 immediately. `PCWrite` equals `NextPC`; `RegWrite`=`MemWrite`=0 with `RegW`=`MemW`=1.
- SUBS zero result:
  - Stimulus: `CondEx`=1 at decode, then exec with `ALUResult`=0, `ALUCarry`=1, `ALUOverflow`=0, `ALUArith`=1, `FlagW`=11.
  - Required: `Flags`=0110 next cycle, `FlagsUpd` pulses once.
- Logic op keeps C/V:
  - Stimulus: from `Flags`=0011, exec with `ALUResult`=0x80000000, `ALUArith`=0, `FlagW`=11.
  - Required: `Flags`=1011.
- Condition fail:
  - Stimulus: latch `CondEx`=0, then exec with `FlagW`=11, `RegW`=`MemW`=`PCS`=1, `NextPC`=0.
  - Required: `Flags` unchanged, `RegWrite`=`MemWrite`=`PCWrite`=0, no `FlagsUpd`.
- Simultaneous strobes:
  - Stimulus: `CondExQ`=1, same cycle `DecodeStrobe`=`ExecStrobe`=1, `CondEx`=0, `FlagW`=10, `ALUResult`=0.
  - Required: Z set next cycle and `CondExQ`=0.
- Partial write:
  - Stimulus: from `Flags`=1100, `FlagW`=01, `ALUArith`=1, `ALUCarry`=1, `ALUOverflow`=1.
  - Required: `Flags`=1111.
